// File: rtl/uart_tx_sched_if.sv
// Requester handshakes plus the transmitter-side strobe/data bundle for uart_tx_sched.
interface uart_tx_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              uart_wr_o;
    logic [7:0]        uart_dat_o;
    logic              busy_o;
    logic [ID_W-1:0]   grant_id_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i,
        output req_ready_o, uart_wr_o, uart_dat_o, busy_o, grant_id_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i,
        input  req_ready_o, uart_wr_o, uart_dat_o, busy_o, grant_id_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one UART transmitter with guard-time spaced write strobes
// and an optional per-requester packet lock with idle timeout.
module uart_tx_sched #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned GAP_CYCLES = 9600,
    parameter int unsigned CNT_W      = 14,
    parameter int unsigned LOCK_TO    = 65535
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_n_i,
    uart_tx_sched_if.slave bus
);
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TO_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic             r_lock;
    logic [ID_W-1:0]  r_rr;
    logic [7:0]       r_dat;
    logic [ID_W-1:0]  r_gid;

    state_t          w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [TO_W-1:0]  w_to_nx;
    logic             w_lock_nx;
    logic [ID_W-1:0]  w_rr_nx;
    logic [7:0]       w_dat_nx;
    logic [ID_W-1:0]  w_gid_nx;
    logic [NREQ-1:0]  w_ready;

    logic [7:0]       w_req_byte [NREQ];
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_pick;
    logic             w_found;
    logic [IW-1:0]    w_owner;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_req_byte[g] = bus.req_data_i[8*g +: 8];
    end

    assign w_owner = IW'(r_gid);

    // Search starts one past the last grant and wraps, so the last owner has lowest priority.
    always_comb begin
        w_idx   = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(r_rr) + k) % NREQ);
            if (!w_found && bus.req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_to_nx    = r_to;
        w_lock_nx  = r_lock;
        w_rr_nx    = r_rr;
        w_dat_nx   = r_dat;
        w_gid_nx   = r_gid;
        w_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_ready    = NREQ'(1) << w_pick;
                    w_dat_nx   = w_req_byte[w_pick];
                    w_gid_nx   = ID_W'(w_pick);
                    w_rr_nx    = ID_W'(w_pick);
                    w_lock_nx  = ~bus.req_last_i[w_pick];
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nx   = CNT_W'(GAP_CYCLES);
                w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // Leave on the cycle the count steps down to 1, giving GAP_CYCLES+1 strobe spacing.
                w_cnt_nx = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(2)) begin
                    if (r_lock) begin
                        w_state_nx = ST_HOLD;
                        w_to_nx    = '0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                w_ready = NREQ'(1) << w_owner;
                if (bus.req_valid_i[w_owner]) begin
                    w_dat_nx   = w_req_byte[w_owner];
                    w_lock_nx  = ~bus.req_last_i[w_owner];
                    w_state_nx = ST_ISSUE;
                end else if ((LOCK_TO != 0) && (r_to == TO_W'(LOCK_TO - 1))) begin
                    w_lock_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_to_nx = r_to + TO_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(GAP_CYCLES);
            r_to    <= '0;
            r_lock  <= 1'b0;
            r_rr    <= ID_W'(NREQ - 1);
            r_dat   <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_to    <= w_to_nx;
            r_lock  <= w_lock_nx;
            r_rr    <= w_rr_nx;
            r_dat   <= w_dat_nx;
            r_gid   <= w_gid_nx;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.uart_wr_o   = (r_state == ST_ISSUE);
    assign bus.uart_dat_o  = r_dat;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.grant_id_o  = r_gid;
endmodule
